// File: rtl/csr_access_ctrl_if.sv
// Request, CSR-file and response signals of csr_access_ctrl.
// master = the controller, slave = pipeline plus CSR register file.
interface csr_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        req_funct3_i;
    logic [11:0]       req_csr_i;
    logic [XLEN-1:0]   req_rs1_data_i;
    logic [4:0]        req_zimm_i;
    logic              req_rs1_zero_i;
    logic              req_rd_zero_i;

    logic [ADDR_W-1:0] csr_addr_o;
    logic              csr_en_read_o;
    logic              csr_en_write_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic [XLEN-1:0]   csr_rdata_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [XLEN-1:0]   rsp_rdata_o;
    logic              rsp_illegal_o;

    modport master (
        input  req_valid_i, req_funct3_i, req_csr_i, req_rs1_data_i,
               req_zimm_i, req_rs1_zero_i, req_rd_zero_i,
               csr_rdata_i, rsp_ready_i,
        output req_ready_o, csr_addr_o, csr_en_read_o, csr_en_write_o,
               csr_wdata_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o
    );

    modport slave (
        output req_valid_i, req_funct3_i, req_csr_i, req_rs1_data_i,
               req_zimm_i, req_rs1_zero_i, req_rd_zero_i,
               csr_rdata_i, rsp_ready_i,
        input  req_ready_o, csr_addr_o, csr_en_read_o, csr_en_write_o,
               csr_wdata_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Zicsr read-modify-write sequencer towards the CSR register file, one op in flight.
// Optional macro CSR_RO_CHECK_EN: reject writing ops to read-only CSRs 0xF11-0xF14.
module csr_access_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    csr_access_ctrl_if.master bus
);
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              rs1_zero_q, rs1_zero_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              illegal_q, illegal_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              en_read_q, en_read_d;
    logic              en_write_q, en_write_d;

    logic [XLEN-1:0]   req_opnd_c;
    logic              req_bad_c;
    logic              req_ro_viol_c;
    logic [XLEN-1:0]   new_val_c;

    function automatic logic csr_legal(input logic [11:0] csr);
        logic ok;
        case (csr)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h306,
            12'h341, 12'h342, 12'h344,
            12'hB00, 12'hB02, 12'hB80, 12'hB82,
            12'hF11, 12'hF12, 12'hF13, 12'hF14: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

`ifdef CSR_RO_CHECK_EN
    // Writing ops (RW always, RS/RC with a non-zero source) to the machine info CSRs
    always_comb begin
        req_ro_viol_c = (bus.req_csr_i >= 12'hF11) && (bus.req_csr_i <= 12'hF14) &&
                        ((bus.req_funct3_i[1:0] == OP_RW) || !bus.req_rs1_zero_i);
    end
`else
    always_comb begin
        req_ro_viol_c = 1'b0;
    end
`endif

    // Request decode: operand select and rejection
    always_comb begin
        req_opnd_c = bus.req_funct3_i[2] ? XLEN'(bus.req_zimm_i) : bus.req_rs1_data_i;
        req_bad_c  = (bus.req_funct3_i[1:0] == 2'b00) || !csr_legal(bus.req_csr_i) ||
                     req_ro_viol_c;
    end

    // Modify step applied to the value arriving from the register file
    always_comb begin
        case (op_q)
            OP_RW:   new_val_c = opnd_q;
            OP_RS:   new_val_c = bus.csr_rdata_i | opnd_q;
            default: new_val_c = bus.csr_rdata_i & ~opnd_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        rs1_zero_d  = rs1_zero_q;
        old_d       = old_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        illegal_d   = illegal_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    op_d       = bus.req_funct3_i[1:0];
                    opnd_d     = req_opnd_c;
                    rs1_zero_d = bus.req_rs1_zero_i;
                    old_d      = '0;
                    if (req_bad_c) begin
                        state_d     = S_RESP;
                        illegal_d   = 1'b1;
                        rdata_d     = '0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        illegal_d = 1'b0;
                        addr_d    = ADDR_W'(bus.req_csr_i);
                        // RW into x0 needs no old value: go straight to the write
                        if ((bus.req_funct3_i[1:0] == OP_RW) && bus.req_rd_zero_i) begin
                            state_d = S_WR;
                            wdata_d = req_opnd_c;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                old_d = bus.csr_rdata_i;
                if ((op_q != OP_RW) && rs1_zero_q) begin
                    state_d     = S_RESP;
                    rdata_d     = bus.csr_rdata_i;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = S_WR;
                    wdata_d = new_val_c;
                end
            end
            S_WR: begin
                state_d     = S_RESP;
                rdata_d     = old_q;
                rsp_valid_d = 1'b1;
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and ready follow the state being entered, so they are flops of the state
        req_ready_d = (state_d == S_IDLE);
        en_read_d   = (state_d == S_RD);
        en_write_d  = (state_d == S_WR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            opnd_q      <= '0;
            rs1_zero_q  <= 1'b0;
            old_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            illegal_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            en_read_q   <= 1'b0;
            en_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            rs1_zero_q  <= rs1_zero_d;
            old_q       <= old_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            illegal_q   <= illegal_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            en_read_q   <= en_read_d;
            en_write_q  <= en_write_d;
        end
    end

    assign bus.req_ready_o    = req_ready_q;
    assign bus.csr_addr_o     = addr_q;
    assign bus.csr_en_read_o  = en_read_q;
    assign bus.csr_en_write_o = en_write_q;
    assign bus.csr_wdata_o    = wdata_q;
    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.rsp_rdata_o    = rdata_q;
    assign bus.rsp_illegal_o  = illegal_q;

    // The register file port cannot read and write in the same cycle
    a_rd_wr_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(en_read_q && en_write_q));
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl with a registered-read CSR file model.
`timescale 1ns/1ps
module tb_csr_access_ctrl;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned XLEN   = 32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        illegal;
        logic [31:0] wdata;
        logic [3:0]  nrd;
        logic [3:0]  nwr;
        logic [3:0]  lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_access_ctrl_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus ();
    csr_access_ctrl #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [31:0] csr_mem [4096];
    logic [31:0] ref_mem [4096];
    logic        pre_we   = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [11:0] cur_csr  = '0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, addr_bad = 0;
    int rd_base = 0, wr_base = 0;
    logic [31:0] last_wdata = '0;

    logic [11:0] legal_list [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h341,
                                     12'h342, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                     12'hF11, 12'hF12, 12'hF13, 12'hF14};

    // CSR register file model plus strobe monitor
    always @(posedge clk) begin
        if (pre_we) csr_mem[pre_addr] <= pre_data;
        else if (bus.csr_en_write_o) csr_mem[bus.csr_addr_o[11:0]] <= bus.csr_wdata_o;
        if (bus.csr_en_read_o) bus.csr_rdata_i <= csr_mem[bus.csr_addr_o[11:0]];
        if (bus.csr_en_read_o) rd_cnt <= rd_cnt + 1;
        if (bus.csr_en_write_o) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= bus.csr_wdata_o;
        end
        if (bus.csr_en_read_o && bus.csr_en_write_o) both_cnt <= both_cnt + 1;
        if ((bus.csr_en_read_o || bus.csr_en_write_o) && (bus.csr_addr_o != ADDR_W'(cur_csr)))
            addr_bad <= addr_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic model(input logic [2:0] f3, input logic [11:0] c, input logic [31:0] rs1,
                         input logic [4:0] zimm, input logic rs1z, input logic rdz,
                         output exp_t e);
        logic [31:0] opnd, old, nv;
        logic legal, ro_bad;
        opnd   = f3[2] ? {27'b0, zimm} : rs1;
        legal  = 1'b0;
        foreach (legal_list[i]) if (legal_list[i] == c) legal = 1'b1;
        ro_bad = 1'b0;
`ifdef CSR_RO_CHECK_EN
        ro_bad = (c >= 12'hF11) && (c <= 12'hF14) && ((f3[1:0] == 2'b01) || !rs1z);
`endif
        e = '0;
        if ((f3[1:0] == 2'b00) || !legal || ro_bad) begin
            e.illegal = 1'b1;
            e.lat     = 4'd1;
        end else if ((f3[1:0] == 2'b01) && rdz) begin
            e.nwr = 4'd1; e.wdata = opnd; e.lat = 4'd2;
            ref_mem[c] = opnd;
        end else begin
            old     = ref_mem[c];
            e.rdata = old;
            e.nrd   = 4'd1;
            case (f3[1:0])
                2'b01:   nv = opnd;
                2'b10:   nv = old | opnd;
                default: nv = old & ~opnd;
            endcase
            if ((f3[1:0] != 2'b01) && rs1z) begin
                e.lat = 4'd3;
            end else begin
                e.nwr = 4'd1; e.wdata = nv; e.lat = 4'd4;
                ref_mem[c] = nv;
            end
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] c, input logic [31:0] rs1,
                         input logic [4:0] zimm, input logic rs1z, input logic rdz);
        exp_t e;
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready_o && n < 20) begin @(negedge clk); n++; end
        check("req_ready", 32'(bus.req_ready_o), 32'd1);
        model(f3, c, rs1, zimm, rs1z, rdz, e);
        sb.push_back(e);
        cur_csr = c;
        rd_base = rd_cnt;
        wr_base = wr_cnt;
        bus.req_funct3_i   = f3;
        bus.req_csr_i      = c;
        bus.req_rs1_data_i = rs1;
        bus.req_zimm_i     = zimm;
        bus.req_rs1_zero_i = rs1z;
        bus.req_rd_zero_i  = rdz;
        bus.req_valid_i    = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int lat;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.rsp_valid_o && lat < 20);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        check("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("latency", 32'(lat), 32'(e.lat));
        check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
        check("rsp_illegal", 32'(bus.rsp_illegal_o), 32'(e.illegal));
        check("n_read", 32'(rd_cnt - rd_base), 32'(e.nrd));
        check("n_write", 32'(wr_cnt - wr_base), 32'(e.nwr));
        if (e.nwr != 0) check("wdata", last_wdata, e.wdata);
        for (int i = 0; i < hold; i++) begin
            bus.req_funct3_i = 3'b001;
            bus.req_csr_i    = 12'h301;
            bus.req_valid_i  = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("hold_rdata", bus.rsp_rdata_o, e.rdata);
            check("hold_ready", 32'(bus.req_ready_o), 32'd0);
        end
        bus.req_valid_i = 1'b0;
        if (hold > 0) check("hold_no_strobe", 32'(rd_cnt - rd_base + wr_cnt - wr_base),
                            32'(e.nrd) + 32'(e.nwr));
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        check("rsp_drop", 32'(bus.rsp_valid_o), 32'd0);
        check("back_idle", 32'(bus.req_ready_o), 32'd1);
    endtask

    task automatic op(input logic [2:0] f3, input logic [11:0] c, input logic [31:0] rs1,
                      input logic [4:0] zimm, input logic rs1z, input logic rdz);
        issue(f3, c, rs1, zimm, rs1z, rdz);
        collect(0);
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.req_funct3_i = '0; bus.req_csr_i = '0;
        bus.req_rs1_data_i = '0; bus.req_zimm_i = '0; bus.req_rs1_zero_i = 1'b0;
        bus.req_rd_zero_i = 1'b0; bus.rsp_ready_i = 1'b0; bus.csr_rdata_i = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_en_read", 32'(bus.csr_en_read_o), 32'd0);
        check("rst_en_write", 32'(bus.csr_en_write_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rsp_illegal", 32'(bus.rsp_illegal_o), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        check("rst_addr", bus.csr_addr_o, 32'd0);
        check("rst_wdata", bus.csr_wdata_o, 32'd0);
        rst_n = 1'b1;

        foreach (legal_list[i]) preload(legal_list[i], 32'h0);
        preload(12'h300, 32'h0000_1800);
        preload(12'h342, 32'h0000_000B);
        preload(12'hF14, 32'h0000_DEAD);

        op(3'b001, 12'h305, 32'h8000_0100, 5'd0, 1'b0, 1'b0);  // RW full RMW
        issue(3'b010, 12'h300, 32'h8, 5'd0, 1'b0, 1'b0);       // RS, response held 5 cycles
        collect(5);
        op(3'b111, 12'h300, 32'h0, 5'd8, 1'b0, 1'b0);          // RCI clears bit 3
        op(3'b010, 12'h342, 32'h0, 5'd0, 1'b1, 1'b0);          // RS read-only
        op(3'b101, 12'h304, 32'h0, 5'd5, 1'b0, 1'b1);          // RWI write-only
        op(3'b001, 12'h7C0, 32'h1, 5'd0, 1'b0, 1'b0);          // unknown CSR
        op(3'b100, 12'h300, 32'h1, 5'd0, 1'b0, 1'b0);          // bad funct3
        op(3'b001, 12'hF14, 32'h1234, 5'd0, 1'b0, 1'b0);       // read-only CSR write
        op(3'b011, 12'h304, 32'h1, 5'd0, 1'b0, 1'b0);          // RC

        for (int k = 0; k < 40; k++) begin
            logic [2:0]  f3;
            logic [11:0] c;
            logic [31:0] rs1;
            logic [4:0]  zimm;
            logic        rs1z;
            case ($urandom_range(0, 7))
                0: f3 = 3'b001; 1: f3 = 3'b010; 2: f3 = 3'b011; 3: f3 = 3'b101;
                4: f3 = 3'b110; 5: f3 = 3'b111; 6: f3 = 3'b010;
                default: f3 = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b100;
            endcase
            c    = ($urandom_range(0, 9) == 0) ? 12'h7C0 : legal_list[$urandom_range(0, 15)];
            rs1z = ($urandom_range(0, 3) == 0);
            rs1  = rs1z ? 32'h0 : $urandom;
            zimm = rs1z ? 5'd0 : 5'($urandom_range(1, 31));
            issue(f3, c, rs1, zimm, rs1z, 1'($urandom_range(0, 1)));
            collect(int'($urandom_range(0, 2)));
        end

        // Reset while the write strobe is up: no write lands, controller back to idle
        @(negedge clk);
        cur_csr = 12'h305;
        rd_base = rd_cnt;
        wr_base = wr_cnt;
        bus.req_funct3_i = 3'b101; bus.req_csr_i = 12'h305; bus.req_zimm_i = 5'd9;
        bus.req_rs1_zero_i = 1'b0; bus.req_rd_zero_i = 1'b1; bus.req_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        check("wr_before_rst", 32'(bus.csr_en_write_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("wr_drop_async", 32'(bus.csr_en_write_o), 32'd0);
        check("rsp_in_rst", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.req_ready_o), 32'd1);
        check("no_aborted_write", 32'(wr_cnt - wr_base), 32'd0);
        op(3'b010, 12'h305, 32'h0, 5'd0, 1'b1, 1'b0);          // old value survives

        check("rd_wr_overlap", 32'(both_cnt), 32'd0);
        check("strobe_addr", 32'(addr_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
